pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports CLK and reset_n; the polarity and synchronicity are fixed.
REQ-002 The module SHALL have the following ports, in this order:
- CLK  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level; begin program execution from PC 0
- halt  input  1  decoded HALT for the current instruction
- branchType  input  2  00 next, 01 return, 10 decrement-branch-if-not-zero, 11 branch-negative
- threewireOffset  input  3  backward offset for type 10
- sixwireOffset  input  6  signed two's-complement offset for type 11
- flag  input  1  ALU flag for the current instruction (1 = zero or negative result)
- returnAddr  input  7  register value used as the type-01 target
- programCounter  output  7  current instruction address
- instrValid  output  1  instruction word is valid, so decode/write-enables may act
- done  output  1  program halted
- cycleCount  output  16  retired-instruction count

Function
REQ-003 The FSM SHALL have four states: IDLE, FETCH, EXEC and DONE.
REQ-004 In IDLE, when start=1 the FSM SHALL go to FETCH with programCounter=0; otherwise it SHALL stay in IDLE.
REQ-005 FETCH SHALL last exactly one cycle, with instrValid=0, and SHALL then go to EXEC; it models the synchronous instruction-memory read.
REQ-006 EXEC SHALL last exactly one cycle with instrValid=1, so each instruction takes 2 cycles.
REQ-007 At the end of EXEC, when halt=1 the FSM SHALL go to DONE and leave programCounter unchanged; halt SHALL override any branchType.
REQ-008 At the end of EXEC, when halt=0 the FSM SHALL go to FETCH and load programCounter with the next PC:
- 00: PC+1
- 01: returnAddr
- 10: flag=0 gives PC - zero-extended threewireOffset; flag=1 gives PC+1
- 11: flag=1 gives PC + sign-extended sixwireOffset; flag=0 gives PC+1
REQ-009 All PC arithmetic SHALL be 7 bits modulo 128 (127+1=0; 0-1=127), with no error indication.
REQ-010 For type 10, threewireOffset=0 with flag=0 SHALL give a self-loop (PC unchanged).
REQ-011 In DONE, done SHALL be 1 and instrValid SHALL be 0.
REQ-012 In DONE, when start=1 the FSM SHALL go to FETCH with programCounter=0; otherwise it SHALL stay in DONE.
REQ-013 start SHALL be ignored in FETCH and EXEC.
REQ-014 branchType, the offsets, flag, returnAddr and halt SHALL be sampled only in EXEC and ignored in every other state.
REQ-015 done SHALL be 0 in every state except DONE.

Reset
REQ-016 While reset_n=0, regardless of CLK, the module SHALL immediately force state=IDLE, programCounter=0, instrValid=0, done=0 and cycleCount=0.
REQ-017 Reset asserted mid-instruction SHALL abandon the instruction; no PC update from that EXEC SHALL occur.
REQ-018 On the first rising edge after reset_n rises, the FSM SHALL evaluate start from IDLE.

Configuration
REQ-019 With CYCLE_COUNT_EN defined, cycleCount SHALL:
- increment by 1 at the end of each EXEC cycle, including the halting one
- saturate at 16'hFFFF
- clear to 0 on each IDLE/DONE to FETCH transition
REQ-020 Without CYCLE_COUNT_EN, cycleCount SHALL be tied to 0 and no counter register SHALL be synthesized; the port SHALL remain present.

Structure
REQ-021 The branchType encodings (BR_NEXT, BR_RETURN, BR_DECNZ, BR_NEG) and the state enum SHALL be defined in package definitions.
REQ-022 The next-PC calculation SHALL be a combinational sub-module, next_pc_calc, with inputs PC, branchType, the offsets, flag and returnAddr, and output nextPC.
REQ-023 The FSM and counter SHALL be in pc_sequencer.

Verification
REQ-024 Sequential run: reset, start=1, branchType=00 and halt=0 for 3 instructions, then halt=1 -> programCounter steps 0,1,2,3 on 2-cycle spacing; done=1 at PC 3; cycleCount=4 when the macro is defined.
REQ-025 Loop: PC=5, type 10, offset=3, flag=0 -> next PC=2; the same with flag=1 -> next PC=6; offset=0 with flag=0 -> PC stays 5.
REQ-026 Branch-negative and wrap: PC=2, type 11, offset=6'b111100 (-4), flag=1 -> PC=126; PC=127, type 00 -> PC=0.
REQ-027 Return and priority: type 01 with returnAddr=7'd77 -> PC=77; type 01 with halt=1 -> DONE with PC unchanged.
REQ-028 Reset and restart: reset_n pulsed low during EXEC -> outputs zero immediately and no PC update; start=1 in DONE -> FETCH with PC=0 and cycleCount cleared.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the PC sequencer: branch-type encodings, FSM states and widths.
package definitions;

  localparam int PC_W  = 7;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    BR_NEXT   = 2'b00,
    BR_RETURN = 2'b01,
    BR_DECNZ  = 2'b10,
    BR_NEG    = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Groups the sequencer's decode-side inputs and status outputs into one bundle for
// whatever drives the sequencer (master) and the sequencer itself (slave).
interface pc_sequencer_if;
  import definitions::*;

  logic             start;
  logic             halt;
  logic [1:0]       branchType;
  logic [2:0]       threewireOffset;
  logic [5:0]       sixwireOffset;
  logic             flag;
  logic [PC_W-1:0]  returnAddr;
  logic [PC_W-1:0]  programCounter;
  logic             instrValid;
  logic             done;
  logic [CNT_W-1:0] cycleCount;

  // instrValid is the only qualifier: decode inputs matter only in a cycle where it is 1.
  modport master (
    output start, halt, branchType, threewireOffset, sixwireOffset, flag, returnAddr,
    input  programCounter, instrValid, done, cycleCount
  );

  modport slave (
    input  start, halt, branchType, threewireOffset, sixwireOffset, flag, returnAddr,
    output programCounter, instrValid, done, cycleCount
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection; all arithmetic wraps modulo 128.
module next_pc_calc
  import definitions::*;
(
  input  logic [PC_W-1:0] PC,
  input  logic [1:0]      branchType,
  input  logic [2:0]      threewireOffset,
  input  logic [5:0]      sixwireOffset,
  input  logic            flag,
  input  logic [PC_W-1:0] returnAddr,
  output logic [PC_W-1:0] nextPC
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_back;
  logic [PC_W-1:0] pc_rel;

  assign pc_inc  = PC + 7'd1;
  assign pc_back = PC - {4'b0000, threewireOffset};
  assign pc_rel  = PC + {sixwireOffset[5], sixwireOffset};

  always_comb begin
    nextPC = pc_inc;
    case (br_type_e'(branchType))
      BR_NEXT:   nextPC = pc_inc;
      BR_RETURN: nextPC = returnAddr;
      // Loop closes while the counted value is non-zero; a zero result falls through.
      BR_DECNZ:  nextPC = flag ? pc_inc : pc_back;
      BR_NEG:    nextPC = flag ? pc_rel : pc_inc;
      default:   nextPC = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Two-cycle-per-instruction program sequencer (FETCH then EXEC).
// Optional retired-instruction counter enabled by defining CYCLE_COUNT_EN.
module pc_sequencer
  import definitions::*;
(
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt,
  input  logic [1:0]       branchType,
  input  logic [2:0]       threewireOffset,
  input  logic [5:0]       sixwireOffset,
  input  logic             flag,
  input  logic [PC_W-1:0]  returnAddr,
  output logic [PC_W-1:0]  programCounter,
  output logic             instrValid,
  output logic             done,
  output logic [CNT_W-1:0] cycleCount
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            instr_valid_q;
  logic            done_q;
  logic [PC_W-1:0] next_pc;

  next_pc_calc u_next_pc_calc (
    .PC              (pc_q),
    .branchType      (branchType),
    .threewireOffset (threewireOffset),
    .sixwireOffset   (sixwireOffset),
    .flag            (flag),
    .returnAddr      (returnAddr),
    .nextPC          (next_pc)
  );

  // Outputs are registered alongside the state so they change exactly on state entry.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= FETCH;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
          end
        end
        FETCH: begin
          state_q       <= EXEC;
          instr_valid_q <= 1'b1;
        end
        EXEC: begin
          instr_valid_q <= 1'b0;
          if (halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
            pc_q    <= next_pc;
          end
        end
        default: begin
          state_q       <= IDLE;
          pc_q          <= '0;
          instr_valid_q <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      cnt_d = '0;
    end else if (state_q == EXEC && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycleCount = cnt_q;
`else
  assign cycleCount = '0;
`endif

  assign programCounter = pc_q;
  assign instrValid     = instr_valid_q;
  assign done           = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: branch vector table plus hand-written run, halt,
// reset and restart sequences.
module tb_pc_sequencer;

  logic CLK = 1'b0;
  logic reset_n;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .CLK             (CLK),
    .reset_n         (reset_n),
    .start           (bus.start),
    .halt            (bus.halt),
    .branchType      (bus.branchType),
    .threewireOffset (bus.threewireOffset),
    .sixwireOffset   (bus.sixwireOffset),
    .flag            (bus.flag),
    .returnAddr      (bus.returnAddr),
    .programCounter  (bus.programCounter),
    .instrValid      (bus.instrValid),
    .done            (bus.done),
    .cycleCount      (bus.cycleCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] pc0;
    logic [1:0] bt;
    logic [2:0] three;
    logic [5:0] six;
    logic       flag;
    logic [6:0] ret;
    logic [6:0] exp_pc;
  } vec_t;

  vec_t        vecs[13];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  logic [6:0]  exp_q[$];

  function automatic logic [15:0] cnt_expected();
`ifdef CYCLE_COUNT_EN
    return exp_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [6:0] pc, input logic iv, input logic dn);
    check({name, ".pc"},    {9'd0, bus.programCounter}, {9'd0, pc});
    check({name, ".valid"}, {15'd0, bus.instrValid},    {15'd0, iv});
    check({name, ".done"},  {15'd0, bus.done},          {15'd0, dn});
    check({name, ".count"}, bus.cycleCount,             cnt_expected());
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Values the DUT must ignore outside EXEC.
  task automatic drive_junk();
    bus.halt            = 1'b1;
    bus.branchType      = 2'b01;
    bus.threewireOffset = 3'd7;
    bus.sixwireOffset   = 6'h2A;
    bus.flag            = 1'b1;
    bus.returnAddr      = 7'h55;
  endtask

  task automatic do_start(input string name);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_cnt   = '0;
    check_outs(name, 7'd0, 1'b0, 1'b0);
  endtask

  // Called while in FETCH; returns one cycle after the EXEC edge.
  task automatic exec_instr(input string name, input logic [1:0] bt, input logic [2:0] three,
                            input logic [5:0] six, input logic fl, input logic [6:0] ret,
                            input logic hlt);
    step();
    check({name, ".exec_valid"}, {15'd0, bus.instrValid}, 16'd1);
    bus.branchType      = bt;
    bus.threewireOffset = three;
    bus.sixwireOffset   = six;
    bus.flag            = fl;
    bus.returnAddr      = ret;
    bus.halt            = hlt;
    step();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    drive_junk();
  endtask

  initial begin
    vecs[0]  = '{7'd5,   2'b10, 3'd3, 6'd0,     1'b0, 7'd0,  7'd2};
    vecs[1]  = '{7'd5,   2'b10, 3'd3, 6'd0,     1'b1, 7'd0,  7'd6};
    vecs[2]  = '{7'd5,   2'b10, 3'd0, 6'd0,     1'b0, 7'd0,  7'd5};
    vecs[3]  = '{7'd2,   2'b11, 3'd0, 6'b111100, 1'b1, 7'd0,  7'd126};
    vecs[4]  = '{7'd127, 2'b00, 3'd0, 6'd0,     1'b0, 7'd0,  7'd0};
    vecs[5]  = '{7'd40,  2'b01, 3'd0, 6'd0,     1'b0, 7'd77, 7'd77};
    vecs[6]  = '{7'd2,   2'b11, 3'd0, 6'b111100, 1'b0, 7'd0,  7'd3};
    vecs[7]  = '{7'd0,   2'b10, 3'd1, 6'd0,     1'b0, 7'd0,  7'd127};
    vecs[8]  = '{7'd120, 2'b11, 3'd0, 6'b011111, 1'b1, 7'd0,  7'd23};
    vecs[9]  = '{7'd10,  2'b10, 3'd7, 6'd0,     1'b0, 7'd0,  7'd3};
    vecs[10] = '{7'd64,  2'b11, 3'd0, 6'b100000, 1'b1, 7'd0,  7'd32};
    vecs[11] = '{7'd9,   2'b00, 3'd5, 6'h15,    1'b1, 7'd99, 7'd10};
    vecs[12] = '{7'd100, 2'b10, 3'd2, 6'd0,     1'b1, 7'd0,  7'd101};

    bus.start = 1'b0;
    drive_junk();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_outs("reset", 7'd0, 1'b0, 1'b0);
    repeat (2) step();
    #2 reset_n = 1'b1;
    step();
    check_outs("idle_hold", 7'd0, 1'b0, 1'b0);

    // Sequential run; start stays high through FETCH/EXEC and must be ignored there.
    bus.start = 1'b1;
    step();
    exp_cnt = '0;
    check_outs("seq_start", 7'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) exp_q.push_back(7'(i));
    for (int i = 0; i < 3; i++) begin
      exec_instr("seq", 2'b00, 3'd0, 6'd0, 1'b0, 7'd0, 1'b0);
      check_outs("seq_step", exp_q.pop_front(), 1'b0, 1'b0);
    end
    bus.start = 1'b0;
    exec_instr("seq_halt", 2'b00, 3'd0, 6'd0, 1'b0, 7'd0, 1'b1);
    check_outs("seq_done", 7'd3, 1'b0, 1'b1);
`ifdef CYCLE_COUNT_EN
    check("seq_count4", bus.cycleCount, 16'd4);
`endif
    repeat (3) step();
    check_outs("done_hold", 7'd3, 1'b0, 1'b1);

    do_start("restart");

    for (int v = 0; v < 13; v++) begin
      exec_instr("vec_setup", 2'b01, 3'd0, 6'd0, 1'b0, vecs[v].pc0, 1'b0);
      check("vec_setup.pc", {9'd0, bus.programCounter}, {9'd0, vecs[v].pc0});
      exec_instr("vec", vecs[v].bt, vecs[v].three, vecs[v].six, vecs[v].flag, vecs[v].ret, 1'b0);
      check_outs($sformatf("vec%0d", v), vecs[v].exp_pc, 1'b0, 1'b0);
    end

    // Halt beats a return branch.
    exec_instr("prio_setup", 2'b01, 3'd0, 6'd0, 1'b0, 7'd33, 1'b0);
    exec_instr("prio", 2'b01, 3'd0, 6'd0, 1'b0, 7'd77, 1'b1);
    check_outs("prio_done", 7'd33, 1'b0, 1'b1);

    // Reset in the middle of an EXEC cycle abandons the instruction.
    do_start("pre_rst");
    exec_instr("pre_rst_jmp", 2'b01, 3'd0, 6'd0, 1'b0, 7'd50, 1'b0);
    step();
    check("rst_in_exec", {15'd0, bus.instrValid}, 16'd1);
    bus.branchType = 2'b01;
    bus.returnAddr = 7'd90;
    bus.halt       = 1'b0;
    #2 reset_n = 1'b0;
    exp_cnt = '0;
    #1;
    check_outs("rst_async", 7'd0, 1'b0, 1'b0);
    step();
    check_outs("rst_held", 7'd0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    step();
    check_outs("rst_idle", 7'd0, 1'b0, 1'b0);
    do_start("post_rst");
    exec_instr("post_rst", 2'b00, 3'd0, 6'd0, 1'b0, 7'd0, 1'b0);
    check_outs("post_rst_step", 7'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
